// File: rtl/aud_ctrl_pkg.sv
// Shared types for the multi-track record/play controller.
package aud_ctrl_pkg;

  // Controller state encodings. These values are visible on o_state.
  localparam logic [2:0] StInit      = 3'd0;
  localparam logic [2:0] StIdle      = 3'd1;
  localparam logic [2:0] StRec       = 3'd2;
  localparam logic [2:0] StRecPause  = 3'd3;
  localparam logic [2:0] StPlay      = 3'd4;
  localparam logic [2:0] StPlayPause = 3'd5;

  // One command pulse group for either the recorder or the DSP.
  typedef struct packed {
    logic start;
    logic pause;
    logic stop;
  } cmd_t;

  // The single key that wins when several arrive in one cycle.
  typedef enum logic [1:0] {KeyNone, KeyStop, KeyRec, KeyPlay} key_e;

  // Resolves simultaneous keys: stop > rec > play.
  function automatic key_e resolve_key(input logic stop, input logic rec, input logic play);
    if (stop) return KeyStop;
    if (rec)  return KeyRec;
    if (play) return KeyPlay;
    return KeyNone;
  endfunction

endpackage

// File: rtl/aud_track_table.sv
// Per-track end-address register file. A track is empty while its end equals its base.
module aud_track_table
  import aud_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned ADDR_W     = 20,
  localparam int unsigned TRK_W     = $clog2(NUM_TRACKS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [TRK_W-1:0]  i_waddr,
  input  logic [ADDR_W-1:0] i_wdata,
  input  logic [TRK_W-1:0]  i_raddr,
  output logic [ADDR_W-1:0] o_rdata,
  input  logic [TRK_W-1:0]  i_chk_idx,
  output logic              o_chk_empty
);

  localparam int unsigned LOW_W = ADDR_W - TRK_W;

  logic [ADDR_W-1:0] end_q [NUM_TRACKS];

  // End addresses reset to each region's base so every track starts empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        end_q[i] <= {TRK_W'(i), {LOW_W{1'b0}}};
      end
    end else if (i_we) begin
      end_q[i_waddr] <= i_wdata;
    end
  end

  // Read port for the active track; a second lookup checks the track about to be played.
  always_comb begin
    o_rdata     = end_q[i_raddr];
    o_chk_empty = (end_q[i_chk_idx] == {i_chk_idx, {LOW_W{1'b0}}});
  end

endmodule

// File: rtl/aud_track_ctrl.sv
// Record/play controller: key FSM, registered command pulses, SRAM arbitration.
module aud_track_ctrl
  import aud_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned ADDR_W     = 20,
  localparam int unsigned TRK_W     = $clog2(NUM_TRACKS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_i2c_fin,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic [TRK_W-1:0]  i_track_sel,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  input  logic              i_rec_fin,
  input  logic              i_play_fin,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_base_addr,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [TRK_W-1:0]  o_track,
  output logic [2:0]        o_state
);

  localparam int unsigned LOW_W = ADDR_W - TRK_W;

  logic [2:0]       state_q, state_d;
  logic [TRK_W-1:0] track_q, track_d;
  cmd_t             rec_cmd_q, rec_cmd_d;
  cmd_t             dsp_cmd_q, dsp_cmd_d;
  logic             restart_q, restart_d;
  logic             end_we;
  logic             sel_empty;
  logic [ADDR_W-1:0] last_word;
  key_e             key;

  aud_track_table #(
    .NUM_TRACKS (NUM_TRACKS),
    .ADDR_W     (ADDR_W)
  ) u_table (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_we        (end_we),
    .i_waddr     (track_q),
    .i_wdata     (i_rec_addr),
    .i_raddr     (track_q),
    .o_rdata     (o_end_addr),
    .i_chk_idx   (i_track_sel),
    .o_chk_empty (sel_empty)
  );

  // Next-state, command pulses and end-address latch decisions.
  always_comb begin
    state_d   = state_q;
    track_d   = track_q;
    rec_cmd_d = '0;
    dsp_cmd_d = '0;
    restart_d = 1'b0;
    end_we    = 1'b0;
    key       = resolve_key(i_key_stop, i_key_rec, i_key_play);
    last_word = {track_q, {LOW_W{1'b1}}};
    case (state_q)
      StInit: if (i_i2c_fin) state_d = StIdle;
      StIdle: begin
        track_d = i_track_sel;
        if (key == KeyRec) begin
          state_d         = StRec;
          rec_cmd_d.start = 1'b1;
        end else if (key == KeyPlay && !sel_empty) begin
          state_d         = StPlay;
          dsp_cmd_d.start = 1'b1;
        end
      end
      StRec: begin
        // Any terminating condition outranks a pause request.
        if (key == KeyStop || i_rec_fin || i_rec_addr == last_word) begin
          state_d        = StIdle;
          rec_cmd_d.stop = 1'b1;
          end_we         = 1'b1;
        end else if (key == KeyRec) begin
          state_d         = StRecPause;
          rec_cmd_d.pause = 1'b1;
        end
      end
      StRecPause: begin
        if (key == KeyStop) begin
          state_d        = StIdle;
          rec_cmd_d.stop = 1'b1;
          end_we         = 1'b1;
        end else if (key == KeyRec) begin
          state_d         = StRec;
          rec_cmd_d.start = 1'b1;
        end
      end
      StPlay: begin
        if (key == KeyStop) begin
          state_d        = StIdle;
          dsp_cmd_d.stop = 1'b1;
        end else if (key == KeyPlay) begin
          state_d         = StPlayPause;
          dsp_cmd_d.pause = 1'b1;
        end else if (i_play_fin) begin
          dsp_cmd_d.stop = 1'b1;
          if (i_loop) restart_d = 1'b1;
          else        state_d   = StIdle;
        end else if (restart_q) begin
          // Second half of a loop restart: start again one cycle after the stop.
          dsp_cmd_d.start = 1'b1;
        end
      end
      StPlayPause: begin
        if (key == KeyStop) begin
          state_d        = StIdle;
          dsp_cmd_d.stop = 1'b1;
        end else if (key == KeyPlay) begin
          state_d         = StPlay;
          dsp_cmd_d.start = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // State and registered command pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StInit;
      track_q   <= '0;
      rec_cmd_q <= '0;
      dsp_cmd_q <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      track_q   <= track_d;
      rec_cmd_q <= rec_cmd_d;
      dsp_cmd_q <= dsp_cmd_d;
      restart_q <= restart_d;
    end
  end

  // Output mapping and SRAM arbitration.
  always_comb begin
    o_rec_start = rec_cmd_q.start;
    o_rec_pause = rec_cmd_q.pause;
    o_rec_stop  = rec_cmd_q.stop;
    o_dsp_start = dsp_cmd_q.start;
    o_dsp_pause = dsp_cmd_q.pause;
    o_dsp_stop  = dsp_cmd_q.stop;
    o_base_addr = {track_q, {LOW_W{1'b0}}};
    o_sram_addr = (state_q == StRec) ? i_rec_addr : i_play_addr;
    o_sram_we_n = (state_q != StRec);
    o_track     = track_q;
    o_state     = state_q;
  end

endmodule

// File: tb/tb_aud_track_ctrl.sv
// Self-checking bench: directed scenarios plus random keys against a behavioural model.
module tb_aud_track_ctrl;

  localparam int unsigned NT = 4;
  localparam int unsigned AW = 20;
  localparam int unsigned TW = 2;
  localparam int REGION = 1 << (AW - TW);

  localparam int M_INIT = 0, M_IDLE = 1, M_REC = 2, M_RPAUSE = 3, M_PLAY = 4, M_PPAUSE = 5;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_i2c_fin = 1'b0;
  logic          i_key_rec = 1'b0, i_key_play = 1'b0, i_key_stop = 1'b0;
  logic [TW-1:0] i_track_sel = '0;
  logic          i_loop = 1'b0;
  logic [AW-1:0] i_rec_addr = '0, i_play_addr = '0;
  logic          i_rec_fin = 1'b0, i_play_fin = 1'b0;
  logic          o_rec_start, o_rec_pause, o_rec_stop;
  logic          o_dsp_start, o_dsp_pause, o_dsp_stop;
  logic [AW-1:0] o_base_addr, o_end_addr, o_sram_addr;
  logic          o_sram_we_n;
  logic [TW-1:0] o_track;
  logic [2:0]    o_state;

  aud_track_ctrl #(
    .NUM_TRACKS (NT),
    .ADDR_W     (AW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_i2c_fin   (i_i2c_fin),
    .i_key_rec   (i_key_rec),
    .i_key_play  (i_key_play),
    .i_key_stop  (i_key_stop),
    .i_track_sel (i_track_sel),
    .i_loop      (i_loop),
    .i_rec_addr  (i_rec_addr),
    .i_play_addr (i_play_addr),
    .i_rec_fin   (i_rec_fin),
    .i_play_fin  (i_play_fin),
    .o_rec_start (o_rec_start),
    .o_rec_pause (o_rec_pause),
    .o_rec_stop  (o_rec_stop),
    .o_dsp_start (o_dsp_start),
    .o_dsp_pause (o_dsp_pause),
    .o_dsp_stop  (o_dsp_stop),
    .o_base_addr (o_base_addr),
    .o_end_addr  (o_end_addr),
    .o_sram_addr (o_sram_addr),
    .o_sram_we_n (o_sram_we_n),
    .o_track     (o_track),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int          m_state;
  int          m_track;
  logic [AW-1:0] m_end [NT];
  bit          m_restart;
  bit          e_rs, e_rp, e_rt, e_ds, e_dp, e_dt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] region_base(input int t);
    return AW'(t * REGION);
  endfunction

  task automatic model_reset();
    m_state   = M_INIT;
    m_track   = 0;
    m_restart = 0;
    {e_rs, e_rp, e_rt, e_ds, e_dp, e_dt} = '0;
    for (int t = 0; t < NT; t++) m_end[t] = region_base(t);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit ks, kr, kp, restart, term;
    ks = i_key_stop;
    kr = i_key_rec && !i_key_stop;
    kp = i_key_play && !i_key_rec && !i_key_stop;
    restart   = m_restart;
    m_restart = 0;
    {e_rs, e_rp, e_rt, e_ds, e_dp, e_dt} = '0;
    case (m_state)
      M_INIT: if (i_i2c_fin) m_state = M_IDLE;
      M_IDLE: begin
        m_track = int'(i_track_sel);
        if (kr) begin
          m_state = M_REC; e_rs = 1;
        end else if (kp && m_end[m_track] != region_base(m_track)) begin
          m_state = M_PLAY; e_ds = 1;
        end
      end
      M_REC: begin
        term = ks || i_rec_fin || (i_rec_addr == region_base(m_track) + AW'(REGION - 1));
        if (term) begin
          m_state = M_IDLE; e_rt = 1; m_end[m_track] = i_rec_addr;
        end else if (kr) begin
          m_state = M_RPAUSE; e_rp = 1;
        end
      end
      M_RPAUSE: begin
        if (ks) begin
          m_state = M_IDLE; e_rt = 1; m_end[m_track] = i_rec_addr;
        end else if (kr) begin
          m_state = M_REC; e_rs = 1;
        end
      end
      M_PLAY: begin
        if (ks) begin
          m_state = M_IDLE; e_dt = 1;
        end else if (kp) begin
          m_state = M_PPAUSE; e_dp = 1;
        end else if (i_play_fin) begin
          e_dt = 1;
          if (i_loop) m_restart = 1;
          else        m_state = M_IDLE;
        end else if (restart) begin
          e_ds = 1;
        end
      end
      M_PPAUSE: begin
        if (ks) begin
          m_state = M_IDLE; e_dt = 1;
        end else if (kp) begin
          m_state = M_PLAY; e_ds = 1;
        end
      end
      default: m_state = M_INIT;
    endcase
  endtask

  task automatic compare_all();
    check_eq("state",     32'(o_state),     32'(m_state));
    check_eq("track",     32'(o_track),     32'(m_track));
    check_eq("rec_start", 32'(o_rec_start), 32'(e_rs));
    check_eq("rec_pause", 32'(o_rec_pause), 32'(e_rp));
    check_eq("rec_stop",  32'(o_rec_stop),  32'(e_rt));
    check_eq("dsp_start", 32'(o_dsp_start), 32'(e_ds));
    check_eq("dsp_pause", 32'(o_dsp_pause), 32'(e_dp));
    check_eq("dsp_stop",  32'(o_dsp_stop),  32'(e_dt));
    check_eq("sram_we_n", 32'(o_sram_we_n), 32'(m_state != M_REC));
    check_eq("sram_addr", 32'(o_sram_addr), 32'((m_state == M_REC) ? i_rec_addr : i_play_addr));
    check_eq("base_addr", 32'(o_base_addr), 32'(region_base(m_track)));
    check_eq("end_addr",  32'(o_end_addr),  32'(m_end[m_track]));
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  task automatic key_tick(input bit rec, input bit play, input bit stop);
    i_key_rec = rec; i_key_play = play; i_key_stop = stop;
    tick();
    i_key_rec = 0; i_key_play = 0; i_key_stop = 0;
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic async_reset();
    i_rst = 1;
    #2;
    model_reset();
    compare_all();
    for (int t = 0; t < NT; t++) check_eq("end_cleared", 32'(dut.u_table.end_q[t]), 32'(t * REGION));
    @(negedge i_clk);
    i_rst = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    compare_all();
    @(negedge i_clk);
    i_rst = 0;

    // Keys are ignored until the codec is initialised.
    key_tick(1, 0, 0);
    key_tick(0, 1, 0);
    check_eq("init_hold", 32'(o_state), 32'(M_INIT));
    i_i2c_fin = 1;
    tick();
    check_eq("init_to_idle", 32'(o_state), 32'(M_IDLE));

    // Record track 2 up to 0x80100, then stop.
    i_track_sel = 2'd2;
    i_rec_addr  = 20'h8_0000;
    tick();
    key_tick(1, 0, 0);
    check_eq("rec_start_t2", 32'(o_rec_start), 32'd1);
    for (int a = 1; a <= 4; a++) begin
      i_rec_addr = 20'h8_0000 + AW'(a * 'h40);
      tick();
    end
    key_tick(0, 0, 1);
    check_eq("rec_stop_t2", 32'(o_rec_stop), 32'd1);
    tick();
    check_eq("end2", 32'(o_end_addr), 32'h8_0100);
    check_eq("base2", 32'(o_base_addr), 32'h8_0000);

    // Empty track 1 refuses to play.
    i_track_sel = 2'd1;
    key_tick(0, 1, 0);
    tick();
    check_eq("empty_play", 32'(o_state), 32'(M_IDLE));

    // Loop playback on track 2, then non-loop finish.
    i_track_sel = 2'd2;
    i_loop      = 1;
    key_tick(0, 1, 0);
    i_play_addr = 20'h8_0080;
    tick();
    i_play_fin = 1;
    tick();
    i_play_fin = 0;
    check_eq("loop_stop", 32'(o_dsp_stop), 32'd1);
    tick();
    check_eq("loop_start", 32'(o_dsp_start), 32'd1);
    check_eq("loop_state", 32'(o_state), 32'(M_PLAY));
    i_loop     = 0;
    i_play_fin = 1;
    tick();
    i_play_fin = 0;
    check_eq("noloop_idle", 32'(o_state), 32'(M_IDLE));

    // Simultaneous rec and stop while recording: stop wins.
    i_rec_addr = 20'h8_0010;
    key_tick(1, 0, 0);
    i_rec_addr = 20'h8_0020;
    key_tick(1, 0, 1);
    check_eq("stop_wins", 32'(o_state), 32'(M_IDLE));
    tick();

    // Track 3 auto-stops at its last word.
    i_track_sel = 2'd3;
    i_rec_addr  = 20'hC_0000;
    key_tick(1, 0, 0);
    i_rec_addr = 20'hF_FFF0;
    tick();
    i_rec_addr = 20'hF_FFFF;
    tick();
    check_eq("auto_stop", 32'(o_rec_stop), 32'd1);
    tick();
    check_eq("end3", 32'(o_end_addr), 32'hF_FFFF);

    // Reset while playing track 3.
    key_tick(0, 1, 0);
    check_eq("play_t3", 32'(o_state), 32'(M_PLAY));
    tick();
    async_reset();
    tick();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 19);
      i_key_stop  = (r == 0) || (r == 3);
      i_key_rec   = (r == 1) || (r == 3) || (r == 4);
      i_key_play  = (r == 2) || (r == 4) || (r == 5);
      i_track_sel = TW'($urandom_range(0, NT - 1));
      i_rec_fin   = ($urandom_range(0, 39) == 0);
      i_play_fin  = ($urandom_range(0, 14) == 0);
      if ((n % 50) == 0) i_loop = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 29) == 0)
        i_rec_addr = region_base(m_track) + AW'(REGION - 1);
      else
        i_rec_addr = region_base(m_track) + AW'($urandom_range(0, REGION - 2));
      i_play_addr = AW'($urandom);
      tick();
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
